// File: rtl/audio_dcblock.sv
// rtl/audio_dcblock.sv - stereo decimator with per-channel first-order DC-blocking IIR
module audio_dcblock #(
    parameter int DIV = 1167,
    parameter int K   = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce,
    input  logic               bypass,
    input  logic [14:0]        inL,
    input  logic [14:0]        inR,
    output logic signed [15:0] left,
    output logic signed [15:0] right,
    output logic               strb
);

    localparam int CW = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, CL, CR, OUT} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               tick;
    logic               prime;
    logic signed [15:0] xl, xr, xpl, xpr;
    logic signed [25:0] al, ar;

    logic signed [15:0] sel_x, sel_xp;
    logic signed [25:0] sel_a, step, leak, a_next;
    logic signed [16:0] diff;

    assign tick = ce && (cnt == CW'(DIV - 1));

    // One adder chain shared by both channels; CR selects the right-hand operands.
    always_comb begin
        sel_x  = (state == CR) ? xr  : xl;
        sel_xp = (state == CR) ? xpr : xpl;
        sel_a  = (state == CR) ? ar  : al;
        diff   = {sel_x[15], sel_x} - {sel_xp[15], sel_xp};
        step   = {diff[16], diff, 8'h00};
        leak   = sel_a >>> K;
        a_next = sel_a + step - leak;
    end

    function automatic logic signed [15:0] sat16(input logic signed [17:0] y);
        if (y > 18'sd32767)
            return 16'sh7fff;
        else if (y < -18'sd32768)
            return 16'sh8000;
        else
            return y[15:0];
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            prime <= 1'b1;
            xl    <= '0;
            xr    <= '0;
            xpl   <= '0;
            xpr   <= '0;
            al    <= '0;
            ar    <= '0;
            left  <= '0;
            right <= '0;
            strb  <= 1'b0;
        end else begin
            strb <= 1'b0;
            if (ce)
                cnt <= tick ? '0 : cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (tick) begin
                        xl    <= $signed({1'b0, inL}) - 16'sh4000;
                        xr    <= $signed({1'b0, inR}) - 16'sh4000;
                        state <= CL;
                    end
                end
                CL: begin
                    if (bypass)
                        al <= '0;
                    else if (!prime)
                        al <= a_next;
                    xpl   <= xl;
                    state <= CR;
                end
                CR: begin
                    if (bypass)
                        ar <= '0;
                    else if (!prime)
                        ar <= a_next;
                    xpr   <= xr;
                    state <= OUT;
                end
                OUT: begin
                    strb <= 1'b1;
                    // Bypass re-arms priming so leaving it does not produce a step.
                    if (bypass) begin
                        left  <= xl;
                        right <= xr;
                        prime <= 1'b1;
                    end else begin
                        left  <= sat16(al[25:8]);
                        right <= sat16(ar[25:8]);
                        prime <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_dcblock.sv
// tb/tb_audio_dcblock.sv - directed self-checking bench for audio_dcblock
module tb_audio_dcblock;

    localparam int DIV = 8;

    logic               clock  = 1'b0;
    logic               reset  = 1'b0;
    logic               ce     = 1'b0;
    logic               bypass = 1'b0;
    logic [14:0]        inL    = '0;
    logic [14:0]        inR    = '0;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               strb;

    int passed = 0;
    int total  = 0;
    bit ce_gate = 1'b0;

    int                 n;
    bit                 ok;
    logic signed [15:0] prev;
    bit                 mono;
    bit                 seen;

    always #5 clock = ~clock;

    audio_dcblock #(.DIV(DIV), .K(10)) dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .bypass(bypass),
        .inL   (inL),
        .inR   (inR),
        .left  (left),
        .right (right),
        .strb  (strb)
    );

    // Returns the number of rising edges until strb is seen high (sampled on falling edges).
    task automatic get_sample(output int cnt, output bit got);
        cnt = 0;
        got = 1'b0;
        while (cnt < 200 && !got) begin
            @(negedge clock);
            cnt++;
            if (ce_gate)
                ce = ~ce;
            if (strb === 1'b1)
                got = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        ce    = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        inL = 15'd0;
        inR = 15'd0;
        #1;
        total++; if (left !== 16'sd0)  $display("FAIL reset_left: got %0d expected 0", left);  else passed++;
        total++; if (right !== 16'sd0) $display("FAIL reset_right: got %0d expected 0", right); else passed++;
        total++; if (strb !== 1'b0)    $display("FAIL reset_strb: got %b expected 0", strb);    else passed++;
        apply_reset();
        get_sample(n, ok);
        total++; if (!ok || n != 11) $display("FAIL first_strb_latency: got %0d edges expected 11", n); else passed++;
        total++; if (left !== 16'sd0)  $display("FAIL prime_left: got %0d expected 0", left);  else passed++;
        total++; if (right !== 16'sd0) $display("FAIL prime_right: got %0d expected 0", right); else passed++;
        @(negedge clock);
        total++; if (strb !== 1'b0) $display("FAIL strb_width: got %b expected 0", strb); else passed++;
        get_sample(n, ok);
        total++; if (!ok || n != DIV - 1) $display("FAIL strb_spacing: got %0d edges expected %0d", n, DIV - 1); else passed++;
        total++; if (left !== 16'sd0 || right !== 16'sd0)
            $display("FAIL zero_input_second: got %0d/%0d expected 0/0", left, right); else passed++;
    endtask

    task automatic test_step();
        inL = 15'd16384;
        inR = 15'd16384;
        apply_reset();
        get_sample(n, ok);
        total++; if (!ok || left !== 16'sd0) $display("FAIL step_prime: got %0d expected 0", left); else passed++;
        inL = 15'd24576;
        get_sample(n, ok);
        total++; if (!ok || left !== 16'sd8192) $display("FAIL step_first: got %0d expected 8192", left); else passed++;
        get_sample(n, ok);
        total++; if (!ok || left !== 16'sd8184) $display("FAIL step_second: got %0d expected 8184", left); else passed++;
        prev = left;
        mono = 1'b1;
        for (int i = 0; i < 9000; i++) begin
            get_sample(n, ok);
            if (!ok || left > prev || left < 16'sd0 || right !== 16'sd0)
                mono = 1'b0;
            prev = left;
        end
        total++; if (mono !== 1'b1) $display("FAIL step_decay_monotonic: got %b expected 1", mono); else passed++;
        total++; if (left > 16'sd3 || left < -16'sd3) $display("FAIL step_settled: got %0d expected |left|<=3", left); else passed++;
    endtask

    task automatic test_full_scale();
        inL = 15'd0;
        inR = 15'd16384;
        apply_reset();
        get_sample(n, ok);
        total++; if (!ok || left !== 16'sd0) $display("FAIL fs_prime: got %0d expected 0", left); else passed++;
        inL = 15'd32767;
        get_sample(n, ok);
        total++; if (!ok || left !== 16'sh7fff) $display("FAIL fs_peak: got %0d expected 32767", left); else passed++;
        get_sample(n, ok);
        total++; if (!ok || left !== 16'sd32735) $display("FAIL fs_next: got %0d expected 32735", left); else passed++;
        total++; if (right !== 16'sd0) $display("FAIL fs_right: got %0d expected 0", right); else passed++;
    endtask

    task automatic test_bypass();
        bypass = 1'b1;
        inL    = 15'd16384;
        inR    = 15'd0;
        get_sample(n, ok);
        total++; if (!ok || right !== -16'sd16384) $display("FAIL bypass_min: got %0d expected -16384", right); else passed++;
        total++; if (left !== 16'sd0) $display("FAIL bypass_left: got %0d expected 0", left); else passed++;
        inR = 15'd32767;
        get_sample(n, ok);
        total++; if (!ok || right !== 16'sd16383) $display("FAIL bypass_max: got %0d expected 16383", right); else passed++;
        bypass = 1'b0;
        get_sample(n, ok);
        total++; if (!ok || right !== 16'sd0) $display("FAIL bypass_exit_prime: got %0d expected 0", right); else passed++;
        inR = 15'd24575;
        get_sample(n, ok);
        total++; if (!ok || right !== -16'sd8192) $display("FAIL bypass_exit_delta: got %0d expected -8192", right); else passed++;
        total++; if (left !== 16'sd0) $display("FAIL bypass_exit_left: got %0d expected 0", left); else passed++;
    endtask

    task automatic test_ce_gating();
        inL = 15'd16384;
        inR = 15'd16384;
        apply_reset();
        ce_gate = 1'b1;
        get_sample(n, ok);
        total++; if (!ok || left !== 16'sd0) $display("FAIL ce_prime: got %0d expected 0", left); else passed++;
        inL = 15'd24576;
        get_sample(n, ok);
        total++; if (!ok || n != 2 * DIV) $display("FAIL ce_period1: got %0d expected %0d", n, 2 * DIV); else passed++;
        total++; if (left !== 16'sd8192) $display("FAIL ce_first: got %0d expected 8192", left); else passed++;
        get_sample(n, ok);
        total++; if (!ok || n != 2 * DIV) $display("FAIL ce_period2: got %0d expected %0d", n, 2 * DIV); else passed++;
        total++; if (left !== 16'sd8184) $display("FAIL ce_second: got %0d expected 8184", left); else passed++;
        ce_gate = 1'b0;
        ce      = 1'b1;
    endtask

    task automatic test_reset_mid();
        inL = 15'd16384;
        inR = 15'd16384;
        apply_reset();
        get_sample(n, ok);
        inL = 15'd24576;
        get_sample(n, ok);
        total++; if (!ok || left !== 16'sd8192) $display("FAIL mid_pre: got %0d expected 8192", left); else passed++;
        // Next tick lands 5 edges after the strobe; one further edge puts the FSM in CR.
        repeat (6) @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (left !== 16'sd0 || right !== 16'sd0 || strb !== 1'b0)
            $display("FAIL mid_async_clear: got %0d/%0d/%b expected 0/0/0", left, right, strb); else passed++;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (strb !== 1'b0)
                seen = 1'b1;
        end
        reset = 1'b1;
        get_sample(n, ok);
        total++; if (seen !== 1'b0 || !ok || n != 11) $display("FAIL mid_no_abort_strb: got %0d edges expected 11", n); else passed++;
        total++; if (left !== 16'sd0) $display("FAIL mid_reprime: got %0d expected 0", left); else passed++;
        get_sample(n, ok);
        total++; if (!ok || n != DIV || left !== 16'sd0)
            $display("FAIL mid_after: got %0d after %0d edges expected 0 after %0d", left, n, DIV); else passed++;
    endtask

    initial begin
        test_reset();
        test_step();
        test_full_scale();
        test_bypass();
        test_ce_gating();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/audio_dcblock.md
Name: audio_dcblock

Overview:
- Stereo audio conditioner between the ts core's 15-bit unsigned `left`/`right` outputs and the i2s serialiser.
- Decimates the audio to a fixed sample rate and removes DC offset with a first-order high-pass (DC-blocking) IIR per channel.
- Presents saturated 16-bit signed samples plus a one-cycle sample strobe.
- Also suppresses the power-on/bypass-exit thump by priming its history on the first sample.

Parameters:
- DIV, 1167, clock-enable ticks per output sample (56 MHz / 1167 ≈ 48 kHz); legal range ≥ 8.
- K, 10, leak shift; pole = 1 - 2^-K (corner ≈ fs / (2π·2^K)).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low; clears all state
- ce  in  1  divider clock enable; divider advances only when 1
- bypass  in  1  1 = pass offset-converted input straight through, no filtering
- inL  in  15  left input, unsigned, mid-scale 16384
- inR  in  15  right input, unsigned, mid-scale 16384
- left  out  16  left output, two's complement
- right  out  16  right output, two's complement
- strb  out  1  one-cycle pulse: new left/right valid

Behaviour:
- Reset (async, reset=0) clears:
  - left=0, right=0, strb=0
  - divider cnt=0, FSM=IDLE, accumulators AL/AR=0, history xpL/xpR=0
  - prime flag=1
- Divider:
  - cnt increments on clock when ce=1; at cnt==DIV-1 with ce=1 it wraps to 0 and issues tick.
  - The first tick is on the DIV-th ce-qualified edge after reset release.
- Sample edge (tick):
  - xL = {1'b0,inL} - 16'h4000 and xR likewise (16-bit signed, range -16384..16383) are registered.
  - FSM moves IDLE→CL.
- FSM:
  - IDLE → CL (on tick) → CR → OUT → IDLE, one state per clock.
  - Fixed and not stallable. DIV ≥ 8 guarantees a tick never arrives outside IDLE.
  - A tick seen while not IDLE is an error and is ignored.
- CL (left datapath, time-shared with CR):
  - A is 26-bit signed, holding y·2^8.
  - A ← A + ((x - xp) <<< 8) - (A >>> K), where >>> is an arithmetic shift.
  - Then xp ← x.
- CR: same operation for the right channel.
- OUT:
  - left/right ← sat16(A >>> 8), clamped to [-32768, 32767].
  - strb=1 for exactly this one cycle; 0 otherwise.
  - left/right hold their value until the next OUT.
- Latency: outputs and strb change on the 3rd clock edge after the sampling edge.
- Prime (prime=1):
  - CL/CR load xp←x only, with A unchanged (0), so the output is 0.
  - prime clears in OUT.
- Bypass:
  - While bypass=1: A←0, xp←x each sample, outputs = x (no saturation needed), prime←1.
  - Leaving bypass therefore primes on the next sample.
- ce=0 freezes the divider only. An in-flight FSM sequence completes.
- reset=0 mid-sequence aborts immediately with no strb. The first post-reset output is again primed.
- Inputs are sampled only at the tick edge; changes between ticks have no effect.

Test Plan:
- Reset/prime:
  - Stimulus: DIV=8, ce=1, inL=inR=0 from reset.
  - Required: the first strb occurs 3 edges after the 8th edge; left=right=0 on the first and all later strobes; strb width is 1 cycle; strb spacing is 8 clocks.
- Step:
  - Stimulus: after priming at inL=16384, step inL to 24576.
  - Required: next left=8192. Subsequent samples decay monotonically (second ≈ 8184). After ≥ 9000 samples |left| ≤ 3. right remains 0.
- Full-scale / saturation:
  - Stimulus: primed at inL=0, then inL=32767.
  - Required: left=32767 (0x7FFF), never negative/wrapped. The next sample is < 32767 and > 32700.
- Bypass:
  - Stimulus: bypass=1, inR=0 → right=-16384; inR=32767 → right=16383.
  - Required: on bypass=0 the next output is 0 (primed), and the following outputs track x deltas only.
- ce gating:
  - Stimulus: ce toggled 1-of-2 cycles.
  - Required: strb period = 2·DIV clocks. Outputs are bit-identical to the ce=1 run for the same sample sequence.
- Reset mid-operation:
  - Stimulus: assert reset in state CR.
  - Required: left/right/strb go to 0 asynchronously; no strb for the aborted sample; post-release behaviour matches the Reset/prime scenario.
